// File: rtl/tone_ctrl_pkg.sv
// Shared types and default widths for the tone sweep controller slice.
package tone_ctrl_pkg;

    localparam int DEFAULT_PHASE_W = 32;
    localparam int DEFAULT_DWELL_W = 24;

    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'd0,
        MODE_REPEAT   = 2'd1,
        MODE_PINGPONG = 2'd2,
        MODE_HOLD     = 2'd3
    } sweep_mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/tone_sweep_controller_if.sv
// Host-side configuration/control bundle and oscillator-facing outputs.
interface tone_sweep_controller_if
    import tone_ctrl_pkg::*;
#(
    parameter int PHASE_W = DEFAULT_PHASE_W,
    parameter int DWELL_W = DEFAULT_DWELL_W
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [PHASE_W-1:0] cfg_start_step;
    logic [PHASE_W-1:0] cfg_stop_step;
    logic [PHASE_W-1:0] cfg_delta;
    logic [DWELL_W-1:0] cfg_dwell;
    logic [1:0]         cfg_mode;
    logic               start;
    logic               abort;
    logic [PHASE_W-1:0] phase_step;
    logic               osc_en;
    logic               busy;
    logic               done;
    logic               wrap;

    modport master (
        output cfg_valid, cfg_start_step, cfg_stop_step, cfg_delta,
               cfg_dwell, cfg_mode, start, abort,
        input  cfg_ready, phase_step, osc_en, busy, done, wrap
    );

    modport slave (
        input  cfg_valid, cfg_start_step, cfg_stop_step, cfg_delta,
               cfg_dwell, cfg_mode, start, abort,
        output cfg_ready, phase_step, osc_en, busy, done, wrap
    );

endinterface

// File: rtl/sweep_dwell_timer.sv
// Dwell down-counter: load sets the count, expire flags count zero.
module sweep_dwell_timer
    import tone_ctrl_pkg::*;
#(
    parameter int DWELL_W = DEFAULT_DWELL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    output logic               expire
);
    logic [DWELL_W-1:0] cnt_q;

    // Load takes precedence; otherwise count down and rest at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/tone_sweep_controller.sv
// Stepped phase_step sweep sequencer with one-shot/repeat/ping-pong/hold modes.
module tone_sweep_controller
    import tone_ctrl_pkg::*;
#(
    parameter int PHASE_W = DEFAULT_PHASE_W,
    parameter int DWELL_W = DEFAULT_DWELL_W
) (
    input logic                clk,
    input logic                rst,
    tone_sweep_controller_if.slave bus
);
    ctrl_state_e        state_q;
    logic [PHASE_W-1:0] start_q, stop_q, delta_q, phase_q;
    logic [DWELL_W-1:0] dwell_q;
    sweep_mode_e        mode_q;
    logic               up_q;      // start_step <= stop_step for this sweep
    logic               ret_q;     // on the ping-pong return leg
    logic               osc_en_q, busy_q, done_q, wrap_q, cfg_ready_q;

    logic               cfg_take, expire, timer_load, at_target, moving_up;
    logic [PHASE_W-1:0] eff_start, eff_stop, target, step_next, turn_next;
    logic [DWELL_W-1:0] timer_val;

    // Move cur by dlt toward tgt, clamping on overshoot, overflow or underflow.
    function automatic logic [PHASE_W-1:0] step_toward(
        input logic [PHASE_W-1:0] cur,
        input logic [PHASE_W-1:0] tgt,
        input logic [PHASE_W-1:0] dlt,
        input logic               up
    );
        logic [PHASE_W:0] nxt;
        if (up) begin
            nxt = {1'b0, cur} + {1'b0, dlt};
            if (nxt[PHASE_W] || (nxt[PHASE_W-1:0] > tgt)) return tgt;
        end else begin
            nxt = {1'b0, cur} - {1'b0, dlt};
            if (nxt[PHASE_W] || (nxt[PHASE_W-1:0] < tgt)) return tgt;
        end
        return nxt[PHASE_W-1:0];
    endfunction

    // A config offered together with start must steer that same sweep.
    assign cfg_take  = cfg_ready_q && bus.cfg_valid;
    assign eff_start = cfg_take ? bus.cfg_start_step : start_q;
    assign eff_stop  = cfg_take ? bus.cfg_stop_step  : stop_q;
    assign timer_val = cfg_take ? bus.cfg_dwell      : dwell_q;

    assign target    = ret_q ? start_q : stop_q;
    assign moving_up = up_q ^ ret_q;
    assign at_target = (phase_q == target);
    assign step_next = step_toward(phase_q, target, delta_q, moving_up);
    assign turn_next = step_toward(phase_q, ret_q ? stop_q : start_q, delta_q, ~moving_up);

    assign timer_load = ((state_q == IDLE) && bus.start && !bus.abort) ||
                        ((state_q == RUN) && expire);

    sweep_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .expire   (expire)
    );

    // Config capture plus the IDLE/RUN sequencer with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            start_q     <= '0;
            stop_q      <= '0;
            delta_q     <= '0;
            dwell_q     <= '0;
            mode_q      <= MODE_ONESHOT;
            phase_q     <= '0;
            up_q        <= 1'b0;
            ret_q       <= 1'b0;
            osc_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wrap_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            if (cfg_take) begin
                start_q <= bus.cfg_start_step;
                stop_q  <= bus.cfg_stop_step;
                delta_q <= bus.cfg_delta;
                dwell_q <= bus.cfg_dwell;
                mode_q  <= sweep_mode_e'(bus.cfg_mode);
            end
            if (bus.abort) begin
                state_q     <= IDLE;
                phase_q     <= '0;
                osc_en_q    <= 1'b0;
                busy_q      <= 1'b0;
                cfg_ready_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start) begin
                            state_q     <= RUN;
                            phase_q     <= eff_start;
                            osc_en_q    <= 1'b1;
                            busy_q      <= 1'b1;
                            cfg_ready_q <= 1'b0;
                            up_q        <= (eff_start <= eff_stop);
                            ret_q       <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (expire) begin
                            if (at_target) begin
                                case (mode_q)
                                    MODE_ONESHOT: begin
                                        state_q     <= IDLE;
                                        done_q      <= 1'b1;
                                        osc_en_q    <= 1'b0;
                                        busy_q      <= 1'b0;
                                        cfg_ready_q <= 1'b1;
                                    end
                                    MODE_REPEAT: begin
                                        wrap_q  <= 1'b1;
                                        phase_q <= start_q;
                                    end
                                    MODE_PINGPONG: begin
                                        wrap_q  <= 1'b1;
                                        ret_q   <= ~ret_q;
                                        phase_q <= turn_next;
                                    end
                                    default: ;
                                endcase
                            end else begin
                                phase_q <= step_next;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.cfg_ready  = cfg_ready_q;
    assign bus.phase_step = phase_q;
    assign bus.osc_en     = osc_en_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.wrap       = wrap_q;

endmodule

// File: tb/tb_tone_sweep_controller.sv
// Self-checking bench for tone_sweep_controller against a trace-level model.
module tb_tone_sweep_controller;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    typedef struct {
        logic [31:0] ph;
        logic        en;
        logic        busy;
        logic        done;
        logic        wrap;
    } exp_t;

    exp_t ref_q[$];

    tone_sweep_controller_if bus ();

    tone_sweep_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void push_exp(input longint ph, input bit en, input bit dn, input bit wr);
        exp_t e;
        e.ph   = ph[31:0];
        e.en   = en;
        e.busy = en;
        e.done = dn;
        e.wrap = wr;
        ref_q.push_back(e);
    endfunction

    // Next step value heading toward t, never passing it.
    function automatic longint move_toward(input longint c, input longint t, input longint d);
        longint r;
        if (t >= c) begin
            r = c + d;
            if (r > t) r = t;
        end else begin
            r = c - d;
            if (r < t) r = t;
        end
        return r;
    endfunction

    // Expected per-cycle outputs, starting with the first cycle after start is taken.
    task automatic build_model(input longint s, input longint e, input longint d,
                               input int w, input int m, input int n);
        longint cur, tgt;
        bit     fwd, wr, fin;
        ref_q.delete();
        cur = s; tgt = e; fwd = 1'b1; wr = 1'b0; fin = 1'b0;
        while (!fin && ref_q.size() < n) begin
            for (int k = 0; k <= w; k++) push_exp(cur, 1'b1, 1'b0, (k == 0) ? wr : 1'b0);
            wr = 1'b0;
            if (cur == tgt) begin
                case (m)
                    0: begin
                        push_exp(cur, 1'b0, 1'b1, 1'b0);
                        while (ref_q.size() < n) push_exp(cur, 1'b0, 1'b0, 1'b0);
                        fin = 1'b1;
                    end
                    1: begin cur = s; wr = 1'b1; end
                    2: begin
                        fwd = !fwd;
                        tgt = fwd ? e : s;
                        cur = move_toward(cur, tgt, d);
                        wr  = 1'b1;
                    end
                    default: ;
                endcase
            end else begin
                cur = move_toward(cur, tgt, d);
            end
        end
    endtask

    task automatic kick(input logic [31:0] s, input logic [31:0] e, input logic [31:0] d,
                        input logic [23:0] w, input logic [1:0] m, input logic with_cfg);
        @(posedge clk); #1;
        bus.cfg_start_step = s;
        bus.cfg_stop_step  = e;
        bus.cfg_delta      = d;
        bus.cfg_dwell      = w;
        bus.cfg_mode       = m;
        bus.cfg_valid      = with_cfg;
        bus.start          = 1'b1;
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.cfg_valid = 1'b0;
    endtask

    task automatic do_abort();
        @(posedge clk); #1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.phase_step, bus.osc_en, bus.busy, bus.done, bus.wrap, bus.cfg_ready} !== {32'd0, 5'b00001}) begin
            errors++;
            $display("FAIL reset_held: got ph=%h en=%b busy=%b done=%b wrap=%b rdy=%b, want 0/0/0/0/0/1",
                     bus.phase_step, bus.osc_en, bus.busy, bus.done, bus.wrap, bus.cfg_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.phase_step, bus.osc_en, bus.busy, bus.done, bus.wrap, bus.cfg_ready} !== {32'd0, 5'b00001}) begin
            errors++;
            $display("FAIL reset_release: got ph=%h en=%b busy=%b done=%b wrap=%b rdy=%b, want 0/0/0/0/0/1",
                     bus.phase_step, bus.osc_en, bus.busy, bus.done, bus.wrap, bus.cfg_ready);
        end
    endtask

    task automatic test_oneshot();
        kick(32'd1000, 32'd1300, 32'd100, 24'd3, 2'd0, 1'b1);
        build_model(1000, 1300, 100, 3, 0, 22);
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.phase_step, bus.osc_en, bus.busy, bus.done, bus.wrap, bus.cfg_ready} !==
                {ref_q[i].ph, ref_q[i].en, ref_q[i].busy, ref_q[i].done, ref_q[i].wrap, ~ref_q[i].busy}) begin
                errors++;
                $display("FAIL oneshot cyc=%0d: got ph=%0d en=%b done=%b wrap=%b rdy=%b, want ph=%0d en=%b done=%b wrap=%b",
                         i, bus.phase_step, bus.osc_en, bus.done, bus.wrap, bus.cfg_ready,
                         ref_q[i].ph, ref_q[i].en, ref_q[i].done, ref_q[i].wrap);
            end
        end
    endtask

    task automatic test_clamp();
        logic [31:0] s [2];
        logic [31:0] e [2];
        logic [31:0] d [2];
        s[0] = 32'hFFFF_FF00; e[0] = 32'hFFFF_FFFF; d[0] = 32'h80;
        s[1] = 32'd250;       e[1] = 32'd0;         d[1] = 32'd100;
        for (int t = 0; t < 2; t++) begin
            kick(s[t], e[t], d[t], 24'd0, 2'd0, 1'b1);
            build_model(s[t], e[t], d[t], 0, 0, 7);
            for (int i = 0; i < 7; i++) begin
                @(negedge clk);
                checks++;
                if ({bus.phase_step, bus.osc_en, bus.busy, bus.done, bus.wrap, bus.cfg_ready} !==
                    {ref_q[i].ph, ref_q[i].en, ref_q[i].busy, ref_q[i].done, ref_q[i].wrap, ~ref_q[i].busy}) begin
                    errors++;
                    $display("FAIL clamp%0d cyc=%0d: got ph=%h en=%b done=%b wrap=%b, want ph=%h en=%b done=%b wrap=%b",
                             t, i, bus.phase_step, bus.osc_en, bus.done, bus.wrap,
                             ref_q[i].ph, ref_q[i].en, ref_q[i].done, ref_q[i].wrap);
                end
            end
        end
    endtask

    task automatic test_pingpong();
        kick(32'd10, 32'd30, 32'd10, 24'd1, 2'd2, 1'b1);
        build_model(10, 30, 10, 1, 2, 30);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.phase_step, bus.osc_en, bus.busy, bus.done, bus.wrap, bus.cfg_ready} !==
                {ref_q[i].ph, ref_q[i].en, ref_q[i].busy, ref_q[i].done, ref_q[i].wrap, ~ref_q[i].busy}) begin
                errors++;
                $display("FAIL pingpong cyc=%0d: got ph=%0d wrap=%b done=%b en=%b, want ph=%0d wrap=%b done=%b en=%b",
                         i, bus.phase_step, bus.wrap, bus.done, bus.osc_en,
                         ref_q[i].ph, ref_q[i].wrap, ref_q[i].done, ref_q[i].en);
            end
        end
        do_abort();
    endtask

    task automatic test_repeat_abort();
        kick(32'd5, 32'd7, 32'd1, 24'd0, 2'd1, 1'b1);
        build_model(5, 7, 1, 0, 1, 5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.phase_step, bus.osc_en, bus.busy, bus.done, bus.wrap} !==
                {ref_q[i].ph, ref_q[i].en, ref_q[i].busy, ref_q[i].done, ref_q[i].wrap}) begin
                errors++;
                $display("FAIL repeat cyc=%0d: got ph=%0d wrap=%b, want ph=%0d wrap=%b",
                         i, bus.phase_step, bus.wrap, ref_q[i].ph, ref_q[i].wrap);
            end
        end
        bus.abort = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.phase_step, bus.osc_en, bus.busy, bus.done, bus.wrap, bus.cfg_ready} !== {32'd0, 5'b00001}) begin
                errors++;
                $display("FAIL abort_idle cyc=%0d: got ph=%0d en=%b busy=%b done=%b wrap=%b rdy=%b, want 0/0/0/0/0/1",
                         i, bus.phase_step, bus.osc_en, bus.busy, bus.done, bus.wrap, bus.cfg_ready);
            end
        end
    endtask

    task automatic test_delta_zero();
        kick(32'd400, 32'd900, 32'd0, 24'd0, 2'd1, 1'b1);
        build_model(400, 900, 0, 0, 1, 1000);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.phase_step, bus.osc_en, bus.busy, bus.done, bus.wrap} !==
                {ref_q[i].ph, ref_q[i].en, ref_q[i].busy, ref_q[i].done, ref_q[i].wrap}) begin
                errors++;
                $display("FAIL delta_zero cyc=%0d: got ph=%0d done=%b wrap=%b, want ph=%0d done=0 wrap=0",
                         i, bus.phase_step, bus.done, bus.wrap, ref_q[i].ph);
            end
        end
        do_abort();
    endtask

    // Random configs; start/cfg_valid noise is injected only while the sweep is running.
    task automatic test_random_run_noise();
        logic [31:0] s, e, d, base;
        int          w, m;
        for (int it = 0; it < 12; it++) begin
            base = $urandom;
            s = ($urandom_range(0, 3) == 0) ? $urandom : base + $urandom_range(0, 400);
            e = ($urandom_range(0, 3) == 0) ? s : base + $urandom_range(0, 400);
            d = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom_range(1, 150);
            w = $urandom_range(0, 3);
            m = $urandom_range(0, 3);
            kick(s, e, d, w[23:0], m[1:0], 1'b1);
            build_model(s, e, d, w, m, 60);
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                checks++;
                if ({bus.phase_step, bus.osc_en, bus.busy, bus.done, bus.wrap, bus.cfg_ready} !==
                    {ref_q[i].ph, ref_q[i].en, ref_q[i].busy, ref_q[i].done, ref_q[i].wrap, ~ref_q[i].busy}) begin
                    errors++;
                    $display("FAIL random it=%0d m=%0d cyc=%0d: got ph=%h en=%b done=%b wrap=%b rdy=%b, want ph=%h en=%b done=%b wrap=%b",
                             it, m, i, bus.phase_step, bus.osc_en, bus.done, bus.wrap, bus.cfg_ready,
                             ref_q[i].ph, ref_q[i].en, ref_q[i].done, ref_q[i].wrap);
                end
                if (ref_q[i].busy) begin
                    bus.start          = $urandom_range(0, 1);
                    bus.cfg_valid      = $urandom_range(0, 1);
                    bus.cfg_start_step = $urandom;
                    bus.cfg_stop_step  = $urandom;
                    bus.cfg_delta      = $urandom;
                    bus.cfg_dwell      = 24'($urandom_range(0, 7));
                    bus.cfg_mode       = 2'($urandom_range(0, 3));
                end else begin
                    bus.start     = 1'b0;
                    bus.cfg_valid = 1'b0;
                end
            end
            bus.start     = 1'b0;
            bus.cfg_valid = 1'b0;
            do_abort();
            @(negedge clk);
            checks++;
            if ({bus.phase_step, bus.osc_en, bus.busy, bus.cfg_ready} !== {32'd0, 3'b001}) begin
                errors++;
                $display("FAIL random_abort it=%0d: got ph=%h en=%b busy=%b rdy=%b, want 0/0/0/1",
                         it, bus.phase_step, bus.osc_en, bus.busy, bus.cfg_ready);
            end
        end
    endtask

    task automatic test_async_rst();
        kick(32'd100, 32'd400, 32'd100, 24'd1, 2'd3, 1'b1);
        build_model(100, 400, 100, 1, 3, 20);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.phase_step, bus.osc_en, bus.busy, bus.done, bus.wrap} !==
                {ref_q[i].ph, ref_q[i].en, ref_q[i].busy, ref_q[i].done, ref_q[i].wrap}) begin
                errors++;
                $display("FAIL hold cyc=%0d: got ph=%0d en=%b done=%b wrap=%b, want ph=%0d en=%b done=0 wrap=0",
                         i, bus.phase_step, bus.osc_en, bus.done, bus.wrap, ref_q[i].ph, ref_q[i].en);
            end
        end
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.phase_step, bus.osc_en, bus.busy, bus.done, bus.wrap, bus.cfg_ready} !== {32'd0, 5'b00001}) begin
            errors++;
            $display("FAIL async_rst: got ph=%0d en=%b busy=%b rdy=%b, want 0/0/0/1",
                     bus.phase_step, bus.osc_en, bus.busy, bus.cfg_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        kick(32'd777, 32'd999, 32'd5, 24'd4, 2'd2, 1'b0);
        build_model(0, 0, 0, 0, 0, 6);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.phase_step, bus.osc_en, bus.busy, bus.done, bus.wrap, bus.cfg_ready} !==
                {ref_q[i].ph, ref_q[i].en, ref_q[i].busy, ref_q[i].done, ref_q[i].wrap, ~ref_q[i].busy}) begin
                errors++;
                $display("FAIL zero_cfg cyc=%0d: got ph=%0d en=%b done=%b rdy=%b, want ph=%0d en=%b done=%b",
                         i, bus.phase_step, bus.osc_en, bus.done, bus.cfg_ready,
                         ref_q[i].ph, ref_q[i].en, ref_q[i].done);
            end
        end
    endtask

    initial begin
        checks             = 0;
        errors             = 0;
        rst                = 1'b1;
        bus.cfg_valid      = 1'b0;
        bus.cfg_start_step = '0;
        bus.cfg_stop_step  = '0;
        bus.cfg_delta      = '0;
        bus.cfg_dwell      = '0;
        bus.cfg_mode       = '0;
        bus.start          = 1'b0;
        bus.abort          = 1'b0;
        test_reset();
        test_oneshot();
        test_clamp();
        test_pingpong();
        test_repeat_abort();
        test_delta_zero();
        test_random_run_noise();
        test_async_rst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
